// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronises ext_reset, debounces the reset button, accepts a software request,
// and releases NUM_DOMAINS active-low resets in staggered order. RST_SINGLE_STEP_EN adds CPU single-step.
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS     = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int STRETCH_CYCLES  = 16,
  parameter int STAGGER_CYCLES  = 4,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                   clkout,
  input  logic                   ext_reset,
  input  logic                   btn_resetn,
  input  logic                   sw_reset_req,
`ifdef RST_SINGLE_STEP_EN
  input  logic                   step_mode,
  input  logic                   step_btn,
`endif
  output logic [NUM_DOMAINS-1:0] rstn_out,
  output logic                   seq_done,
  output logic [1:0]             reset_cause,
  output logic                   cpu_ce
);

  localparam int MAX_SS = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
  localparam int MAX_P  = (MAX_SS > DEBOUNCE_CYCLES) ? MAX_SS : DEBOUNCE_CYCLES;
  localparam int CNT_W  = $clog2(MAX_P) + 1;
  localparam int RI_W   = $clog2(NUM_DOMAINS) + 1;

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RI_W-1:0]  RI_LAST      = RI_W'(NUM_DOMAINS - 1);

  localparam logic [1:0] CAUSE_EXT = 2'd0;
  localparam logic [1:0] CAUSE_BTN = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;

  typedef enum logic [2:0] {HOLD, RELEASE, RUN, DEBOUNCE, WAIT_REL} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic                   rst_int_n;
  logic                   btn_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [RI_W-1:0]        ri_q, ri_d;
  logic [NUM_DOMAINS-1:0] rstn_q, rstn_d;
  logic                   done_q, done_d;
  logic [1:0]             cause_q, cause_d;

  // Deassertion of ext_reset and the raw button both cross into clkout here
  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      rst_sync_q <= '0;
      btn_sync_q <= '1;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn_resetn};
    end
  end

  assign rst_int_n = rst_sync_q[SYNC_STAGES-1];
  assign btn_s     = btn_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      ri_q    <= '0;
      rstn_q  <= '0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_EXT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ri_q    <= ri_d;
      rstn_q  <= rstn_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ri_d    = ri_q;
    rstn_d  = rstn_q;
    done_d  = done_q;
    cause_d = cause_q;
    cnt_inc = sat_inc(cnt_q);
    if (!rst_int_n) begin
      state_d = HOLD;
      cnt_d   = '0;
      ri_d    = '0;
      rstn_d  = '0;
      done_d  = 1'b0;
      cause_d = CAUSE_EXT;
    end else if (sw_reset_req) begin
      state_d = HOLD;
      cnt_d   = '0;
      ri_d    = '0;
      rstn_d  = '0;
      done_d  = 1'b0;
      cause_d = CAUSE_SW;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == STRETCH_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RELEASE: begin
          if (cnt_q == STAGGER_LAST) begin
            cnt_d = '0;
            ri_d  = ri_q + 1'b1;
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (ri_q == RI_W'(i)) rstn_d[i] = 1'b1;
            end
            if (ri_q == RI_LAST) begin
              done_d  = 1'b1;
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RUN: begin
          if (!btn_s) begin
            state_d = DEBOUNCE;
            cnt_d   = '0;
          end
        end
        DEBOUNCE: begin
          // Entry counts as the first low sample, so completion lands on the DEBOUNCE_CYCLES-th
          if (btn_s) begin
            state_d = RUN;
          end else if (cnt_inc == DEB_LAST) begin
            state_d = WAIT_REL;
            cnt_d   = '0;
            ri_d    = '0;
            rstn_d  = '0;
            done_d  = 1'b0;
            cause_d = CAUSE_BTN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        WAIT_REL: begin
          if (btn_s) begin
            state_d = HOLD;
            cnt_d   = '0;
            ri_d    = '0;
          end
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          ri_d    = '0;
        end
      endcase
    end
  end

  assign rstn_out    = rstn_q;
  assign seq_done    = done_q;
  assign reset_cause = cause_q;

`ifdef RST_SINGLE_STEP_EN
  logic [SYNC_STAGES-1:0] step_sync_q;
  logic [CNT_W-1:0]       step_cnt_q, step_cnt_d;
  logic                   step_wait_q, step_wait_d;
  logic                   step_pulse_q, step_pulse_d;
  logic                   step_s;

  assign step_s = step_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      step_sync_q  <= '1;
      step_cnt_q   <= '0;
      step_wait_q  <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      step_sync_q  <= {step_sync_q[SYNC_STAGES-2:0], step_btn};
      step_cnt_q   <= step_cnt_d;
      step_wait_q  <= step_wait_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  // One pulse per press; step_wait holds off re-triggering until the button is released
  always_comb begin
    step_cnt_d   = step_cnt_q;
    step_wait_d  = step_wait_q;
    step_pulse_d = 1'b0;
    if (step_s) begin
      step_cnt_d  = '0;
      step_wait_d = 1'b0;
    end else if (!step_wait_q) begin
      if (step_cnt_q == DEB_LAST) begin
        step_pulse_d = 1'b1;
        step_wait_d  = 1'b1;
      end else begin
        step_cnt_d = sat_inc(step_cnt_q);
      end
    end
  end

  assign cpu_ce = ~step_mode | ~(&rstn_q) | step_pulse_q;
`else
  assign cpu_ce = 1'b1;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl with DEBOUNCE_CYCLES = 8, directed steps then random button/sw traffic.
module tb_rst_seq_ctrl;

  localparam int N     = 3;
  localparam int SYNC  = 2;
  localparam int STR   = 16;
  localparam int STG   = 4;
  localparam int DEB   = 8;
  localparam int DONEE = STR + N * STG;

  logic         clkout;
  logic         ext_reset;
  logic         btn_resetn;
  logic         sw_reset_req;
  logic [N-1:0] rstn_out;
  logic         seq_done;
  logic [1:0]   reset_cause;
  logic         cpu_ce;
`ifdef RST_SINGLE_STEP_EN
  logic         step_mode;
  logic         step_btn;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = in external reset/synchronising, 1 = sequencing, 2 = running, 3 = waiting for button release
  int         m_mode;
  int         m_sync;
  int         m_e;
  int         m_streak;
  logic [1:0] m_cause;
  logic       m_q[$];

  rst_seq_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clkout      (clkout),
    .ext_reset   (ext_reset),
    .btn_resetn  (btn_resetn),
    .sw_reset_req(sw_reset_req),
`ifdef RST_SINGLE_STEP_EN
    .step_mode   (step_mode),
    .step_btn    (step_btn),
`endif
    .rstn_out    (rstn_out),
    .seq_done    (seq_done),
    .reset_cause (reset_cause),
    .cpu_ce      (cpu_ce)
  );

  initial clkout = 1'b0;
  always #5 clkout = ~clkout;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_async_reset();
    m_mode   = 0;
    m_sync   = 0;
    m_e      = 0;
    m_streak = 0;
    m_cause  = 2'd0;
    m_q.delete();
    for (int i = 0; i < SYNC; i++) m_q.push_back(1'b1);
  endtask

  // Domain i is released STR + (i+1)*STG edges after the sequence origin
  function automatic logic [N-1:0] exp_mask();
    logic [N-1:0] m;
    m = '0;
    if (m_mode == 2) m = '1;
    else if (m_mode == 1)
      for (int i = 0; i < N; i++) m[i] = (m_e >= STR + (i + 1) * STG);
    return m;
  endfunction

  task automatic model_edge();
    logic seen;
    if (!ext_reset) begin
      model_async_reset();
      return;
    end
    seen = m_q[0];
    void'(m_q.pop_front());
    m_q.push_back(btn_resetn);
    if (m_sync < SYNC) begin
      m_sync++;
      if (m_sync == SYNC) begin
        m_mode = 1;
        m_e    = 0;
      end
    end else if (sw_reset_req) begin
      m_mode  = 1;
      m_e     = 0;
      m_cause = 2'd2;
    end else begin
      case (m_mode)
        1: begin
          m_e++;
          if (m_e >= DONEE) begin
            m_mode   = 2;
            m_streak = 0;
          end
        end
        2: begin
          m_streak = seen ? 0 : m_streak + 1;
          if (m_streak >= DEB) begin
            m_mode  = 3;
            m_cause = 2'd1;
          end
        end
        3: if (seen) begin
          m_mode = 1;
          m_e    = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    logic skip_ce;
    chk("rstn_out", 8'(rstn_out), 8'(exp_mask()));
    chk("seq_done", 8'(seq_done), 8'(m_mode == 2));
    chk("reset_cause", 8'(reset_cause), 8'(m_cause));
    skip_ce = 1'b0;
`ifdef RST_SINGLE_STEP_EN
    skip_ce = step_mode && (&rstn_out);
`endif
    if (!skip_ce) chk("cpu_ce", 8'(cpu_ce), 8'd1);
  endtask

  task automatic tick();
    @(posedge clkout);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int remaining;
    int pulses;
    ext_reset    = 1'b1;
    btn_resetn   = 1'b1;
    sw_reset_req = 1'b0;
`ifdef RST_SINGLE_STEP_EN
    step_mode = 1'b0;
    step_btn  = 1'b1;
`endif
    model_async_reset();
    #2 ext_reset = 1'b0;
    repeat (3) tick();
    chk("por_rstn", 8'(rstn_out), 8'h00);
    chk("por_cause", 8'(reset_cause), 8'h00);

    // Power-on release: edges counted from the first edge after rst_int_n rises
    ext_reset = 1'b1;
    repeat (SYNC) tick();
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 19) chk("por_edge19", 8'(rstn_out), 8'b000);
      if (e == 20) chk("por_edge20", 8'(rstn_out), 8'b001);
      if (e == 24) chk("por_edge24", 8'(rstn_out), 8'b011);
      if (e == 28) begin
        chk("por_edge28", 8'(rstn_out), 8'b111);
        chk("por_done28", 8'(seq_done), 8'd1);
      end
    end

    // Short press is rejected
    btn_resetn = 1'b0;
    repeat (5) tick();
    btn_resetn = 1'b1;
    repeat (20) tick();
    chk("short_rstn", 8'(rstn_out), 8'b111);
    chk("short_cause", 8'(reset_cause), 8'd0);

    // Long press resets, then the sequence repeats after release
    btn_resetn = 1'b0;
    repeat (12) tick();
    chk("long_rstn", 8'(rstn_out), 8'b000);
    chk("long_cause", 8'(reset_cause), 8'd1);
    btn_resetn = 1'b1;
    repeat (40) tick();
    chk("long_rerun", 8'(rstn_out), 8'b111);

    // Software reset, then a second request at edge 22 restarts the sequence
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    chk("sw_rstn", 8'(rstn_out), 8'b000);
    chk("sw_cause", 8'(reset_cause), 8'd2);
    repeat (21) tick();
    chk("sw_edge21", 8'(rstn_out), 8'b001);
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    chk("sw2_rstn", 8'(rstn_out), 8'b000);
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 19) chk("sw2_edge19", 8'(rstn_out), 8'b000);
      if (e == 20) chk("sw2_edge20", 8'(rstn_out), 8'b001);
    end
    repeat (10) tick();

    // Asynchronous assertion of ext_reset mid-release
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    for (int k = 0; k < 100 && !(m_mode == 1 && m_e >= STR + 2 * STG); k++) tick();
    chk("async_pre", 8'(rstn_out), 8'b011);
    #3 ext_reset = 1'b0;
    #1;
    chk("async_rstn", 8'(rstn_out), 8'b000);
    chk("async_done", 8'(seq_done), 8'd0);
    chk("async_cause", 8'(reset_cause), 8'd0);
    model_async_reset();
    repeat (2) tick();
    ext_reset = 1'b1;
    repeat (40) tick();

    // Software request on the same edge the debounce would complete
    btn_resetn = 1'b0;
    for (int k = 0; k < 100 && !(m_mode == 2 && m_streak == DEB - 1); k++) tick();
    chk("simul_pre", 8'(rstn_out), 8'b111);
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    chk("simul_cause", 8'(reset_cause), 8'd2);
    chk("simul_rstn", 8'(rstn_out), 8'b000);
    repeat (10) tick();
    btn_resetn = 1'b1;
    repeat (30) tick();

`ifdef RST_SINGLE_STEP_EN
    step_mode    = 1'b1;
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    repeat (35) tick();
    chk("step_idle_ce", 8'(cpu_ce), 8'd0);
    pulses   = 0;
    step_btn = 1'b0;
    repeat (12) begin tick(); pulses += int'(cpu_ce); end
    step_btn = 1'b1;
    repeat (10) begin tick(); pulses += int'(cpu_ce); end
    chk("step_long", 8'(pulses), 8'd1);
    pulses   = 0;
    step_btn = 1'b0;
    repeat (5) begin tick(); pulses += int'(cpu_ce); end
    step_btn = 1'b1;
    repeat (10) begin tick(); pulses += int'(cpu_ce); end
    chk("step_short", 8'(pulses), 8'd0);
    step_mode = 1'b0;
    tick();
`endif

    // Random button presses and sparse software requests
    remaining = 0;
    pulses    = 0;
    for (int c = 0; c < 800; c++) begin
      if (remaining == 0) begin
        btn_resetn = ~btn_resetn;
        remaining  = btn_resetn ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 14));
      end
      remaining--;
      sw_reset_req = ($urandom_range(0, 63) == 0);
      tick();
    end
    sw_reset_req = 1'b0;
    btn_resetn   = 1'b1;
    repeat (40) tick();
    chk("final_rstn", 8'(rstn_out), 8'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
